// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and types for the single-clock show-ahead FIFO.
// Capacity is the RAM depth plus the output register.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_SIZE = 8;
  localparam int unsigned DEF_PTR_SIZE  = 8;
  localparam int unsigned DEF_FILL_W    = DEF_PTR_SIZE + 1;

  function automatic int unsigned fifo_cap(input int unsigned ptr_size);
    return (32'd1 << ptr_size) + 32'd1;
  endfunction

  function automatic int unsigned fill_width(input int unsigned ptr_size);
    return ptr_size + 32'd1;
  endfunction

  typedef struct packed {
    logic full;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// read data output. The array is intentionally not reset.
module sync_fifo_ram #(
  parameter int unsigned data_w = 8,
  parameter int unsigned addr_w = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [addr_w-1:0] waddr,
  input  logic [data_w-1:0] wdata,
  input  logic              re,
  input  logic [addr_w-1:0] raddr,
  output logic [data_w-1:0] rdata
);

  logic [data_w-1:0] mem_q [0:(1<<addr_w)-1];
  logic [data_w-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO: RAM, one prefetch stage and an
// output register, with exact fill level, almost flags and sticky errors.
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int unsigned fifo_data_size     = DEF_DATA_SIZE,
  parameter int unsigned fifo_ptr_size      = DEF_PTR_SIZE,
  parameter int unsigned almost_full_margin = 4,
  parameter int unsigned almost_empty_level = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      wr_valid,
  input  logic [fifo_data_size-1:0] wr_data,
  input  logic                      rd_valid,
  output logic [fifo_data_size-1:0] rd_data,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      fifo_almost_full,
  output logic                      fifo_almost_empty,
  output logic [fifo_ptr_size:0]    fill_level,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned FILL_W = fill_width(fifo_ptr_size);
  localparam logic [FILL_W-1:0] CAP       = FILL_W'(fifo_cap(fifo_ptr_size));
  localparam logic [FILL_W-1:0] AF_MARGIN = FILL_W'(almost_full_margin);
  localparam logic [FILL_W-1:0] AE_LEVEL  = FILL_W'(almost_empty_level);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [fifo_ptr_size-1:0] PTR_ONE = fifo_ptr_size'(1);

  logic [fifo_ptr_size-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  logic                      pf_vld_q, pf_vld_d, out_vld_q, out_vld_d;
  logic [fifo_data_size-1:0] data_q, data_d, ram_rdata;
  fifo_flags_t               flags_q, flags_d;
  logic                      ovf_q, ovf_d, udf_q, udf_d;
  logic                      wr_acc, pop, pf_move, ram_ne, rd_issue;
  logic                      ram_we, ram_re;

  sync_fifo_ram #(
    .data_w (fifo_data_size),
    .addr_w (fifo_ptr_size)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Words still sitting in RAM = fill minus the prefetch and output stages.
  assign ram_ne = fill_q > (FILL_W'(pf_vld_q) + FILL_W'(out_vld_q));

  always_comb begin
    wr_acc   = wr_valid && !flags_q.full;
    pop      = rd_valid && out_vld_q;
    pf_move  = pf_vld_q && (!out_vld_q || pop);
    // The prefetch stage may refill in the same cycle it hands its word on.
    rd_issue = ram_ne && (!pf_vld_q || pf_move);

    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    pf_vld_d  = pf_vld_q;
    out_vld_d = out_vld_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      fill_d    = '0;
      pf_vld_d  = 1'b0;
      out_vld_d = 1'b0;
      data_d    = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end else begin
      ram_we = wr_acc;
      ram_re = rd_issue;
      if (wr_acc)   wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_issue) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_acc && !pop) fill_d = fill_q + FILL_ONE;
      if (!wr_acc && pop) fill_d = fill_q - FILL_ONE;
      if (pf_move) begin
        out_vld_d = 1'b1;
        data_d    = ram_rdata;
      end else if (pop) begin
        out_vld_d = 1'b0;
      end
      if (rd_issue)     pf_vld_d = 1'b1;
      else if (pf_move) pf_vld_d = 1'b0;
      ovf_d = ovf_q || (wr_valid && flags_q.full);
      udf_d = udf_q || (rd_valid && !out_vld_q);
    end

    flags_d.full         = (fill_d == CAP);
    flags_d.almost_full  = ((CAP - fill_d) <= AF_MARGIN);
    flags_d.almost_empty = (fill_d <= AE_LEVEL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      pf_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      flags_q   <= '{full: 1'b0, almost_full: 1'b0, almost_empty: 1'b1};
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      pf_vld_q  <= pf_vld_d;
      out_vld_q <= out_vld_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      flags_q   <= flags_d;
    end
  end

  assign rd_data           = data_q;
  assign fifo_empty        = !out_vld_q;
  assign fifo_full         = flags_q.full;
  assign fifo_almost_full  = flags_q.almost_full;
  assign fifo_almost_empty = flags_q.almost_empty;
  assign fill_level        = fill_q;
  assign overflow          = ovf_q;
  assign underflow         = udf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: queue-based reference model (2-edge show-ahead
// latency, capacity 257) driven by directed and random scenarios.
module tb_sync_fifo_fwft;

  localparam int CAP = (1 << 8) + 1;

  logic       clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic       wr_valid = 1'b0, rd_valid = 1'b0;
  logic [7:0] wr_data = '0, rd_data;
  logic       fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic [8:0] fill_level;
  logic       overflow, underflow;

  int n_tests = 0, n_fail = 0;

  sync_fifo_fwft dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_valid(wr_valid),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_almost_full(fifo_almost_full), .fifo_almost_empty(fifo_almost_empty),
    .fill_level(fill_level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: every held word with the edge number it was written on.
  typedef struct { logic [7:0] d; int we; } ent_t;
  ent_t q[$];
  int   e = 0;
  bit   m_ovf = 0, m_udf = 0;

  // A word is visible at the head once two edges have passed since its write.
  function automatic bit m_empty();
    return (q.size() == 0) || (q[0].we >= e - 1);
  endfunction

  function automatic logic [14:0] m_status();
    logic [8:0] f;
    f = 9'(q.size());
    return {m_empty(), q.size() == CAP, (CAP - q.size()) <= 4, q.size() <= 2,
            m_ovf, m_udf, f};
  endfunction

  function automatic logic [14:0] obs();
    return {fifo_empty, fifo_full, fifo_almost_full, fifo_almost_empty,
            overflow, underflow, fill_level};
  endfunction

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f);
    bit   emp, ful;
    ent_t tmp;
    wr_valid = w; wr_data = d; rd_valid = r; flush = f;
    emp = m_empty();
    ful = (q.size() == CAP);
    @(posedge clk);
    e++;
    if (f) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      if (r && emp) m_udf = 1;
      if (w && ful) m_ovf = 1;
      if (r && !emp) tmp = q.pop_front();
      if (w && !ful) begin tmp.d = d; tmp.we = e; q.push_back(tmp); end
    end
    #1;
    wr_valid = 0; rd_valid = 0; flush = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (obs() !== 15'b1001_00_000000000) begin
      n_fail++; $display("FAIL reset_status got %b want %b", obs(), 15'b1001_00_000000000);
    end
    n_tests++;
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    reset = 0;
    q.delete(); m_ovf = 0; m_udf = 0;
  endtask

  task automatic test_latency();
    step(1, 8'hA5, 0, 0);
    n_tests++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL lat_edgeN empty got %b want 1", fifo_empty); end
    step(0, 8'h00, 0, 0);
    n_tests++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL lat_edgeN1 empty got %b want 1", fifo_empty); end
    step(0, 8'h00, 0, 0);
    n_tests++;
    if ({fifo_empty, rd_data, fill_level} !== {1'b0, 8'hA5, 9'd1}) begin
      n_fail++; $display("FAIL lat_edgeN2 empty/data/fill got %b/%h/%0d want 0/a5/1", fifo_empty, rd_data, fill_level);
    end
    step(0, 8'h00, 1, 0);
    n_tests++;
    if (obs() !== m_status()) begin n_fail++; $display("FAIL lat_pop status got %b want %b", obs(), m_status()); end
  endtask

  task automatic test_fill();
    bit af_bad = 0;
    for (int i = 0; i < CAP; i++) begin
      step(1, 8'(i), 0, 0);
      if (fifo_almost_full !== ((i + 1) >= 253)) af_bad = 1;
    end
    n_tests++;
    if (af_bad) begin n_fail++; $display("FAIL fill_almost_full threshold got mistimed want first at 253"); end
    n_tests++;
    if ({fifo_full, fill_level} !== {1'b1, 9'd257}) begin
      n_fail++; $display("FAIL fill_full got full=%b fill=%0d want 1/257", fifo_full, fill_level);
    end
    step(1, 8'hEE, 0, 0);
    n_tests++;
    if ({overflow, fill_level} !== {1'b1, 9'd257}) begin
      n_fail++; $display("FAIL fill_overflow got ovf=%b fill=%0d want 1/257", overflow, fill_level);
    end
    step(1, 8'h77, 1, 0);
    n_tests++;
    if ({overflow, fifo_full, fill_level} !== {1'b1, 1'b0, 9'd256}) begin
      n_fail++; $display("FAIL full_wr_rd got ovf=%b full=%b fill=%0d want 1/0/256", overflow, fifo_full, fill_level);
    end
    for (int k = 0; k < 256; k++) begin
      n_tests++;
      if ({fifo_empty, rd_data} !== {1'b0, 8'(k + 1)}) begin
        n_fail++; $display("FAIL drain_order[%0d] got empty=%b data=%h want 0/%h", k, fifo_empty, rd_data, 8'(k + 1));
      end
      step(0, 8'h00, 1, 0);
    end
    n_tests++;
    if (obs() !== 15'b1001_10_000000000) begin
      n_fail++; $display("FAIL drain_end status got %b want %b", obs(), 15'b1001_10_000000000);
    end
  endtask

  task automatic test_underflow();
    step(0, 8'h00, 1, 0);
    n_tests++;
    if ({underflow, fifo_empty, fill_level} !== {1'b1, 1'b1, 9'd0}) begin
      n_fail++; $display("FAIL underflow got udf=%b empty=%b fill=%0d want 1/1/0", underflow, fifo_empty, fill_level);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 10; i++) step(1, 8'(8'h40 + i), 0, 0);
    repeat (3) step(0, 8'h00, 0, 0);
    n_tests++;
    if (fill_level !== 9'd10) begin n_fail++; $display("FAIL flush_pre fill got %0d want 10", fill_level); end
    step(1, 8'h99, 0, 1);
    n_tests++;
    if ({fill_level, fifo_empty, overflow, underflow} !== {9'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL flush got fill=%0d empty=%b ovf=%b udf=%b want 0/1/0/0", fill_level, fifo_empty, overflow, underflow);
    end
    repeat (3) step(0, 8'h00, 0, 0);
    n_tests++;
    if ({fill_level, fifo_empty} !== {9'd0, 1'b1}) begin
      n_fail++; $display("FAIL flush_drop got fill=%0d empty=%b want 0/1", fill_level, fifo_empty);
    end
  endtask

  task automatic test_stream();
    int wi = 0, ri = 0, bad_data = 0, gaps = 0, bad_fill = 0;
    bit r;
    for (int c = 0; c < 1100 && ri < 1000; c++) begin
      r = !m_empty();
      if (r && rd_data !== 8'(ri * 37 + 5)) bad_data++;
      if (ri > 0 && wi < 1000 && fifo_empty) gaps++;
      if (ri > 0 && wi < 1000 && fill_level !== 9'd3) bad_fill++;
      step(wi < 1000, 8'(wi * 37 + 5), r, 0);
      if (wi < 1000) wi++;
      if (r) ri++;
    end
    n_tests++;
    if (ri != 1000 || bad_data != 0) begin
      n_fail++; $display("FAIL stream_data got read=%0d bad=%0d want 1000/0", ri, bad_data);
    end
    n_tests++;
    if (gaps != 0 || bad_fill != 0) begin
      n_fail++; $display("FAIL stream_rate got gaps=%0d unstable_fill=%0d want 0/0", gaps, bad_fill);
    end
    n_tests++;
    if ({overflow, underflow} !== 2'b00) begin
      n_fail++; $display("FAIL stream_errors got ovf=%b udf=%b want 0/0", overflow, underflow);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int pw, pr;
    for (int c = 0; c < 3000; c++) begin
      pw = ((c / 500) % 2 == 0) ? 90 : 25;
      pr = ((c / 500) % 2 == 0) ? 20 : 80;
      step($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
           $urandom_range(299) == 0);
      n_tests++;
      if (obs() !== m_status() || (!m_empty() && rd_data !== q[0].d)) begin
        n_fail++; bad++;
        if (bad < 10) $display("FAIL random[%0d] got %b/%h want %b/%h", c, obs(), rd_data,
                               m_status(), m_empty() ? rd_data : q[0].d);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) step(1, 8'(i + 1), i > 2, 0);
    #2 reset = 1;
    #1;
    n_tests++;
    if ({obs(), rd_data} !== {15'b1001_00_000000000, 8'h00}) begin
      n_fail++; $display("FAIL async_reset got %b/%h want %b/00", obs(), rd_data, 15'b1001_00_000000000);
    end
    q.delete(); m_ovf = 0; m_udf = 0;
    @(posedge clk); @(negedge clk);
    reset = 0;
    step(1, 8'h3C, 0, 0);
    step(1, 8'h11, 0, 0);
    step(0, 8'h00, 0, 0);
    n_tests++;
    if ({fifo_empty, rd_data, fill_level} !== {1'b0, 8'h3C, 9'd2}) begin
      n_fail++; $display("FAIL post_reset got empty=%b data=%h fill=%0d want 0/3c/2", fifo_empty, rd_data, fill_level);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_underflow();
    test_flush();
    test_stream();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
